// File: rtl/inst_seq_pkg.sv
// Shared definitions for the LA32R multi-cycle instruction sequencer.
// Holds the sequencer state encoding, the default reset PC, the PC
// increment and the opcode prefix that identifies the break instruction.
package inst_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam logic [16:0] BREAK_OP17       = 17'h00054;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // break is recognised by its upper 17 bits; the 15-bit code field is ignored.
  function automatic logic is_break(input logic [31:0] inst);
    return inst[31:15] == BREAK_OP17;
  endfunction

endpackage

// File: rtl/inst_seq.sv
// inst_seq: multi-cycle instruction sequencer for the LA32R single-issue core.
// Owns the PC, fetches one instruction at a time, holds it in the instruction
// register for the decoder, captures the ALU result and issues one register
// file write per instruction. Stops permanently (until reset) when break retires.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   pause               blocks the start of a new fetch
//   imem_req/addr       instruction fetch request and address (addr == pc)
//   imem_valid/rdata    fetch response, consumed only while imem_req is high
//   ir                  instruction register, feeds the decoder
//   pc                  PC of the current instruction, also ALU src0
//   dec_rf_we           decoder write enable for ir
//   alu_res             combinational ALU result
//   rf_we, rf_wd        register file write strobe and registered write data
//   commit, commit_pc   one-cycle retire pulse and PC of the retiring instruction
//   halted              high once break has retired
module inst_seq
  import inst_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic        dec_rf_we,
  input  logic [31:0] alu_res,
  output logic        rf_we,
  output logic [31:0] rf_wd,
  output logic        commit,
  output logic [31:0] commit_pc,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        we_lat_q, we_lat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      rf_wd_q  <= '0;
      we_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      rf_wd_q  <= rf_wd_d;
      we_lat_q <= we_lat_d;
    end
  end

  // Strobes are decoded straight from the state so that an asynchronous
  // reset drops an in-flight request or write in the same cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_wd_d  = rf_wd_q;
    we_lat_d = we_lat_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    commit   = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = !pause;
        if (imem_req && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Decoder and ALU have had a full cycle to settle on ir/pc.
        rf_wd_d  = alu_res;
        we_lat_d = dec_rf_we;
        state_d  = ST_EXEC == state_q ? ST_WB : state_q;
      end
      ST_WB: begin
        rf_we   = we_lat_q;
        commit  = 1'b1;
        pc_d    = pc_q + PC_STEP;
        state_d = is_break(ir_q) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign rf_wd     = rf_wd_q;
  assign commit_pc = pc_q;

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq. A transaction-level model predicts PC,
// IR, fetch requests and retire events; directed sequences add literal
// checks for latency, halting, pausing, reset during write-back and PC wrap.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] alu_res;

  logic        imem_req, rf_we, commit, halted, dec_rf_we;
  logic [31:0] imem_addr, ir, pc, rf_wd, commit_pc;

  logic        imem_req2, rf_we2, commit2, halted2, dec_rf_we2;
  logic [31:0] imem_addr2, ir2, pc2, rf_wd2, commit_pc2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Decoder stub: only addi.w (opcode 0x00A in bits 31:22) writes a register.
  assign dec_rf_we  = (ir[31:22] == 10'h00A);
  assign dec_rf_we2 = (ir2[31:22] == 10'h00A);

  inst_seq dut (
    .clk(clk), .rst(rst), .pause(pause),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .dec_rf_we(dec_rf_we), .alu_res(alu_res),
    .rf_we(rf_we), .rf_wd(rf_wd), .commit(commit), .commit_pc(commit_pc),
    .halted(halted)
  );

  // Second instance starts at the top of the address space to exercise wrap.
  inst_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pause(pause),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ir(ir2), .pc(pc2), .dec_rf_we(dec_rf_we2), .alu_res(alu_res),
    .rf_we(rf_we2), .rf_wd(rf_wd2), .commit(commit2), .commit_pc(commit_pc2),
    .halted(halted2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one expected retire record per accepted fetch.
  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [31:0] wd;
    logic        brk;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_ir;
  bit          model_fetch;
  bit          model_halted;
  bit          exp_commit;
  int          mcyc    = 0;
  int          due_cyc = 0;

  // Compare process: every falling edge checks the DUT against the model,
  // then advances the model by what happened in this cycle.
  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      checkOutput("rst_pc", pc, 32'h1C00_0000);
      checkOutput("rst_ir", ir, 32'h0);
      checkOutput("rst_rf_wd", rf_wd, 32'h0);
      checkOutput("rst_rf_we", 32'(rf_we), 32'h0);
      checkOutput("rst_commit", 32'(commit), 32'h0);
      checkOutput("rst_commit_pc", commit_pc, 32'h1C00_0000);
      checkOutput("rst_halted", 32'(halted), 32'h0);
      checkOutput("rst_imem_req", 32'(imem_req), 32'(!pause));
      exp_q.delete();
      model_pc     = 32'h1C00_0000;
      model_ir     = 32'h0;
      model_fetch  = 1'b1;
      model_halted = 1'b0;
    end else begin
      checkOutput("model_pc", pc, model_pc);
      checkOutput("model_ir", ir, model_ir);
      checkOutput("model_halted", 32'(halted), 32'(model_halted));
      checkOutput("model_imem_req", 32'(imem_req), 32'(model_fetch && !pause));
      if (model_fetch && !pause)
        checkOutput("model_imem_addr", imem_addr, model_pc);
      exp_commit = (exp_q.size() > 0) && (mcyc == due_cyc);
      checkOutput("model_commit", 32'(commit), 32'(exp_commit));
      if (exp_commit) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("model_commit_pc", commit_pc, e.pc);
        checkOutput("model_rf_we", 32'(rf_we), 32'(e.we));
        checkOutput("model_rf_wd", rf_wd, e.wd);
        model_pc = model_pc + 32'd4;
        if (e.brk) model_halted = 1'b1;
        else       model_fetch  = 1'b1;
      end else begin
        checkOutput("model_rf_we_idle", 32'(rf_we), 32'h0);
      end
      if (model_fetch && !pause && imem_valid) begin
        exp_t n;
        n.pc  = model_pc;
        n.we  = (imem_rdata[31:22] == 10'h00A);
        n.wd  = alu_res;
        n.brk = (imem_rdata[31:15] == 17'h00054);
        exp_q.push_back(n);
        model_ir    = imem_rdata;
        model_fetch = 1'b0;
        due_cyc     = mcyc + 2;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Called just after a rising edge in FETCH. Holds imem_valid low for
  // 'delay' cycles with junk data, then offers 'instr' and waits for retire.
  // Returns at the falling edge of the retire cycle.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] alu,
                               input int delay, output int cycles, output int reqs);
    bit done;
    cycles     = 0;
    reqs       = 0;
    alu_res    = alu;
    imem_rdata = 32'hDEAD_BEEF;
    imem_valid = 1'b0;
    repeat (delay) begin
      @(negedge clk);
      cycles++;
      if (imem_req) reqs++;
      nextCycle();
    end
    imem_rdata = instr;
    imem_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      cycles++;
      if (imem_req) reqs++;
      if (commit) done = 1'b1;
      else begin
        nextCycle();
        imem_valid = 1'b0;
      end
    end
    if (!done) checkOutput("commit_timeout", 32'h0, 32'h1);
  endtask

  int cyc_n, req_n;

  initial begin
    rst        = 1'b1;
    pause      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0280_04A5;
    alu_res    = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] addi.w with zero fetch latency");
    applyStimulus(32'h0280_04A5, 32'd1, 0, cyc_n, req_n);
    checkOutput("t1_cycles", 32'(cyc_n), 32'd3);
    checkOutput("t1_commit_pc", commit_pc, 32'h1C00_0000);
    checkOutput("t1_rf_we", 32'(rf_we), 32'h1);
    checkOutput("t1_rf_wd", rf_wd, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_next_addr", imem_addr, 32'h1C00_0004);
    checkOutput("t1_next_req", 32'(imem_req), 32'h1);
    nextCycle();

    $display("[TB] fetch delayed by four cycles");
    applyStimulus(32'h0280_04A5, 32'd7, 4, cyc_n, req_n);
    checkOutput("t2_cycles", 32'(cyc_n), 32'd7);
    checkOutput("t2_req_cycles", 32'(req_n), 32'd5);
    checkOutput("t2_commit_pc", commit_pc, 32'h1C00_0004);
    checkOutput("t2_rf_wd", rf_wd, 32'd7);
    nextCycle();

    $display("[TB] unsupported opcode retires as nop");
    applyStimulus(32'hFFFF_FFFF, 32'h55, 0, cyc_n, req_n);
    checkOutput("t3_commit", 32'(commit), 32'h1);
    checkOutput("t3_rf_we", 32'(rf_we), 32'h0);
    checkOutput("t3_commit_pc", commit_pc, 32'h1C00_0008);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_pc_next", pc, 32'h1C00_000C);
    nextCycle();

    $display("[TB] pause raised during execute");
    alu_res    = 32'd3;
    imem_rdata = 32'h0280_04A5;
    imem_valid = 1'b1;
    @(negedge clk);
    nextCycle();
    pause      = 1'b1;
    imem_valid = 1'b0;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_commit", 32'(commit), 32'h1);
    checkOutput("t4_commit_pc", commit_pc, 32'h1C00_000C);
    checkOutput("t4_rf_wd", rf_wd, 32'd3);
    nextCycle();
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_paused_req", 32'(imem_req), 32'h0);
      nextCycle();
    end
    pause      = 1'b0;
    imem_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_resume_req", 32'(imem_req), 32'h1);
    checkOutput("t4_resume_addr", imem_addr, 32'h1C00_0010);
    nextCycle();

    $display("[TB] break halts the sequencer");
    applyStimulus(32'h002A_0005, 32'hAA, 0, cyc_n, req_n);
    checkOutput("t5_commit_pc", commit_pc, 32'h1C00_0010);
    checkOutput("t5_rf_we", 32'(rf_we), 32'h0);
    nextCycle();
    imem_valid = 1'b1;
    @(negedge clk);
    checkOutput("t5_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      pause = (i % 2) == 1;
      @(negedge clk);
      checkOutput("t5_halt_req", 32'(imem_req), 32'h0);
      checkOutput("t5_halt_pc", pc, 32'h1C00_0014);
    end
    nextCycle();
    pause = 1'b0;

    $display("[TB] reset during write-back");
    rst        = 1'b1;
    imem_valid = 1'b0;
    nextCycle();
    rst        = 1'b0;
    alu_res    = 32'd9;
    imem_rdata = 32'h0280_04A5;
    imem_valid = 1'b1;
    @(negedge clk);
    nextCycle();
    imem_valid = 1'b0;
    @(negedge clk);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rf_we", 32'(rf_we), 32'h0);
    checkOutput("t6_commit", 32'(commit), 32'h0);
    checkOutput("t6_pc", pc, 32'h1C00_0000);
    nextCycle();
    rst = 1'b0;

    $display("[TB] clean restart and PC wrap");
    applyStimulus(32'h0280_04A5, 32'd11, 0, cyc_n, req_n);
    checkOutput("t7_cycles", 32'(cyc_n), 32'd3);
    checkOutput("t7_commit_pc", commit_pc, 32'h1C00_0000);
    checkOutput("t7_rf_wd", rf_wd, 32'd11);
    checkOutput("t7_wrap_commit_pc", commit_pc2, 32'hFFFF_FFFC);
    nextCycle();
    @(negedge clk);
    checkOutput("t7_wrap_addr", imem_addr2, 32'h0);
    checkOutput("t7_wrap_req", 32'(imem_req2), 32'h1);
    checkOutput("t7_next_addr", imem_addr, 32'h1C00_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_seq.md
# inst_seq

Multi-cycle instruction sequencer for the LA32R single-issue core. It owns the PC and fetches one instruction at a time over a request/valid instruction-memory port, then holds it in an instruction register that feeds the decoder. It captures the ALU result and issues exactly one register-file write per instruction. It also stops the core on `break`, and sits between instruction memory, the decoder, the ALU and the register file.

## Interface
- `RESET_PC`, default 32'h1C00_0000: PC value after reset.
- `clk` input 1: core clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `pause` input 1: while high, no new fetch is started; in-flight instruction completes.
- `imem_req` output 1: fetch request, held until accepted.
- `imem_addr` output 32: fetch address, equals `pc` while `imem_req`.
- `imem_valid` input 1: fetch data valid; accepted only while `imem_req`=1.
- `imem_rdata` input 32: fetched instruction.
- `ir` output 32: instruction register, drives decoder `inst`.
- `pc` output 32: PC of the current instruction, also drives ALU src0 when `alu_src0_sel`=1.
- `dec_rf_we` input 1: decoder write-enable for `ir`.
- `alu_res` input 32: combinational ALU result.
- `rf_we` output 1: gated register-file write strobe.
- `rf_wd` output 32: registered write data.
- `commit` output 1: one-cycle pulse on instruction retire.
- `commit_pc` output 32: PC of the retiring instruction, valid with `commit`.
- `halted` output 1: high once `break` retires, until reset.

## Operation
- States: FETCH, EXEC, WB, HALT.
- FETCH:
  - `imem_req`=!`pause`.
  - When `imem_req`&&`imem_valid`: `ir`<=`imem_rdata`, go EXEC.
  - Otherwise stay; no timeout.
- EXEC: decoder and ALU settle on `ir`/`pc`. Latch `rf_wd`<=`alu_res` and a copy of `dec_rf_we`, then go WB.
- WB:
  - `rf_we`=latched `dec_rf_we`, `commit`=1, `commit_pc`=`pc`.
  - `pc`<=`pc`+4, with modulo 2^32 wrap; 32'hFFFF_FFFC goes to 0.
  - Next state is FETCH, or HALT if `ir`[31:15]==17'h00054 (`break`, code field ignored).
- HALT:
  - All strobes low, `halted`=1, `pc` frozen.
  - `pause` and `imem_valid` are ignored.
  - Only `rst` exits.
- Unsupported opcodes: the decoder yields `dec_rf_we`=0, so the instruction retires as a NOP (commit pulses, no write).
- `break` retires with `rf_we`=0 and `commit`=1. `pc` still advances by 4 before HALT.
- `imem_valid` outside FETCH is ignored; there is only ever one outstanding fetch.
- `pause` rising in EXEC/WB has no effect until the next FETCH.

## Timing
- Reset values:
  - state=FETCH, `pc`=`RESET_PC`, `ir`=0, `rf_wd`=0.
  - `rf_we`=0, `commit`=0, `commit_pc`=`RESET_PC`, `halted`=0.
  - `imem_req`=!`pause` combinationally.
- Minimum 3 cycles per instruction when `imem_valid` is high in the first FETCH cycle. Each extra FETCH cycle with `imem_valid` low adds 1.
- `rf_we` and `commit` are exactly one cycle wide, in the same cycle, and never high outside WB.
- `rst` mid-instruction drops the fetch or write immediately. The memory must tolerate `imem_req` falling with no response consumed.
- `rst` and `imem_valid` in the same cycle: reset wins, `ir` stays 0.
- `pause` and `imem_valid` in the same FETCH cycle: `imem_req`=0, so the data is not accepted.

## Structure
- Shared package `inst_seq_pkg`:
  - State enum (2-bit).
  - `RESET_PC` default.
  - `BREAK_OP17`=17'h00054.
  - `PC_STEP`=4.
- Single flat module, no sub-module. The decoder and ALU are instantiated by the core top and connected to `ir`, `pc`, `dec_rf_we` and `alu_res`.

## Test plan
- Reset, `imem_valid` tied 1, memory returns 0x028004A5 (addi.w r5,r5,1) and `alu_res`=1 → `rf_we` pulses on cycle 3 with `rf_wd`=1 and `commit_pc`=0x1C000000. Next `imem_addr`=0x1C000004.
- `imem_valid` delayed 4 cycles → `imem_req` held 5 cycles, `ir` captured only on the valid cycle, total 7 cycles per instruction.
- Instruction 0xFFFFFFFF (unsupported, `dec_rf_we`=0) → `commit`=1, `rf_we`=0, PC+4.
- Fetch 0x002A0005 (`break` 5) → `commit`=1, `rf_we`=0, `halted`=1 the next cycle. `imem_req` stays 0 for 20 cycles and `pc`=old+4.
- `pause`=1 asserted during EXEC → current instruction retires, FETCH holds with `imem_req`=0. Deasserting `pause` resumes the fetch at PC+4.
- `rst` pulsed in WB → no `rf_we`, `pc`=0x1C000000, fetch restarts cleanly. Also start from `pc`=0xFFFFFFFC → next `imem_addr`=0.
